ram_16k: RTL and testbench

- 16384-word x 16-bit random-access memory: the data-memory block of the hand-built computer (Hack-style RAM16K).
- Synchronous write on the rising clock edge when load is high; combinational (asynchronous) read of the addressed word.
- Built hierarchically: 4 banks of 4K words selected by address[13:12]; each bank may itself decompose down to 8-word RAM8 slices.

---
 rtl/ram_16k.sv | 131 +++++++++++++
 tb/tb_ram_16k.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_16k.sv
// ram_16k: 16384 x 16-bit Hack-style data memory, four 4K banks selected by address[13:12].
// Latency: read is combinational (0 cycles), write lands on the rising edge of clk.
// Backpressure: none; a write is accepted every cycle that load is high.
//
// Ports:
//   clk      - system clock, writes on posedge
//   rst_n    - asynchronous active-low reset, clears every word
//   in       - write data
//   load     - write enable, active high
//   address  - word address for read and write
//   out      - contents of the addressed word
//
// Optional feature macro: RAM16K_WRITE_THROUGH_EN
//   When defined, out forwards `in` while load=1 (and rst_n=1), ahead of the edge.

// ---------------------------------------------------------------------------
// ram_16k_bank: one 4K-word bank with asynchronous clear.
// Latency: read 0 cycles, write on posedge.
// Backpressure: none.
//
// Ports: clk, rst_n, in (write data), load (bank-qualified write enable),
//        address (word index inside the bank), out (addressed word).
// ---------------------------------------------------------------------------
module ram_16k_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_dat_d;

  always_comb begin
    wr_en_d   = load;
    wr_addr_d = address;
    wr_dat_d  = in;
  end

  // Reset has priority over a coincident write edge, so the word stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (wr_en_d) begin
      mem_q[wr_addr_d] <= wr_dat_d;
    end
  end

  assign out = mem_q[address];

endmodule

// ---------------------------------------------------------------------------
// ram_16k: top level, bank decode and read mux.
// Latency: read 0 cycles, write on posedge.
// Backpressure: none.
// ---------------------------------------------------------------------------
module ram_16k #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);

  localparam int NUM_BANKS = 4;
  localparam int BANK_AW   = ADDR_W - 2;

  logic [1:0]         bank_sel;
  logic [BANK_AW-1:0] bank_addr;
  logic [DATA_W-1:0]  bank_out [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_load;
  logic [DATA_W-1:0]  rd_dat;

  assign bank_sel  = address[ADDR_W-1 -: 2];
  assign bank_addr = address[BANK_AW-1:0];

  // Only the selected bank sees load; the others hold their contents.
  always_comb begin
    bank_load = '0;
    bank_load[bank_sel] = load;
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    ram_16k_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (BANK_AW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in),
      .load    (bank_load[g]),
      .address (bank_addr),
      .out     (bank_out[g])
    );
  end

  // Fully decoded mux: an unselected bank never reaches out.
  always_comb begin
    rd_dat = '0;
    case (bank_sel)
      2'd0:    rd_dat = bank_out[0];
      2'd1:    rd_dat = bank_out[1];
      2'd2:    rd_dat = bank_out[2];
      2'd3:    rd_dat = bank_out[3];
      default: rd_dat = '0;
    endcase
  end

  // Reset forces out to zero regardless of storage or forwarding.
`ifdef RAM16K_WRITE_THROUGH_EN
  assign out = !rst_n ? '0 : (load ? in : rd_dat);
`else
  assign out = !rst_n ? '0 : rd_dat;
`endif

endmodule

// File: tb/tb_ram_16k.sv
module tb_ram_16k;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [13:0] address;
  logic [15:0] out;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain word array, written only on a clocked load.
  logic [15:0] model [16384];

  ram_16k dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s addr=%0d got=%h exp=%h", tag, address, got, exp);
    end
  endtask

  task automatic model_clear();
    foreach (model[i]) model[i] = 16'h0000;
  endtask

  // Read with no clock edge involved.
  task automatic rd(input string tag, input logic [13:0] a);
    address = a;
    #1;
    chk(tag, out, model[a]);
  endtask

  // One write: check out before the edge and immediately after it.
  task automatic wr(input string tag, input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    #1;
`ifdef RAM16K_WRITE_THROUGH_EN
    chk({tag, "_pre"}, out, d);
`else
    chk({tag, "_pre"}, out, model[a]);
`endif
    @(posedge clk);
    #1;
    model[a] = d;
    chk({tag, "_post"}, out, d);
    load = 1'b0;
  endtask

  logic [13:0] sc_addr [8];
  logic [15:0] sc_dat  [8];

  initial begin
    rst_n   = 1'b1;
    in      = 16'h0000;
    load    = 1'b0;
    address = 14'd2112;
    model_clear();

    // Reset
    #2 rst_n = 1'b0;
    #1 chk("rst_low_out", out, 16'h0000);
    #9 rst_n = 1'b1;
    rd("rst_a0", 14'd0);
    rd("rst_a1", 14'd1);
    rd("rst_a2112", 14'd2112);
    rd("rst_a16383", 14'd16383);

    // Sequential writes 0..7 with data N000
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      d = 16'(i) << 12;
      wr("seq", 14'(i), d);
    end

    // Scattered writes, then a clockless sweep
    sc_addr = '{14'd16, 14'd17, 14'd27, 14'd35, 14'd58, 14'd63, 14'd1111, 14'd2112};
    sc_dat  = '{16'h0016, 16'h0017, 16'h0027, 16'h0035, 16'h0058, 16'h0063, 16'h1111, 16'h2112};
    for (int i = 0; i < 8; i++) wr("scat", sc_addr[i], sc_dat[i]);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      address = sc_addr[i];
      #1 chk("sweep", out, sc_dat[i]);
    end
    address = 14'd0;
    #1 chk("sweep_a0", out, 16'h0000);

    // Load gating: three edges with load low must not disturb address 5
    @(negedge clk);
    address = 14'd5;
    in      = 16'hABCD;
    load    = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("gate_a5", out, 16'h5000);

    // Bank isolation
    wr("bank1", 14'd4096, 16'hAAAA);
    wr("bank2", 14'd8192, 16'hBBBB);
    wr("bank3", 14'd12288, 16'hCCCC);
    wr("bank3_top", 14'd16383, 16'hDDDD);
    @(negedge clk);
    rd("iso_4096", 14'd4096);
    rd("iso_8192", 14'd8192);
    rd("iso_12288", 14'd12288);
    rd("iso_16383", 14'd16383);
    chk("iso_16383_val", out, 16'hDDDD);
    rd("iso_a0", 14'd0);
    rd("iso_4095", 14'd4095);
    chk("iso_4095_zero", out, 16'h0000);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [13:0] a;
      logic [15:0] d;
      logic        ld;
      a  = 14'($urandom_range(0, 16383));
      if (n % 4 == 0) a = 14'($urandom_range(0, 31)) | (14'($urandom_range(0, 3)) << 12);
      d  = 16'($urandom);
      ld = 1'($urandom_range(0, 1));
      @(negedge clk);
      address = a;
      in      = d;
      load    = ld;
      #1;
`ifdef RAM16K_WRITE_THROUGH_EN
      chk("rnd_pre", out, ld ? d : model[a]);
`else
      chk("rnd_pre", out, model[a]);
`endif
      @(posedge clk);
      #1;
      if (ld) model[a] = d;
      chk("rnd_post", out, model[a]);
      load = 1'b0;
      rd("rnd_rd", 14'($urandom_range(0, 16383)));
    end

    // Async reset mid-operation; writes attempted while held are ignored
    wr("pre_rst", 14'd300, 16'h1357);
    @(negedge clk);
    address = 14'd300;
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_out", out, 16'h0000);
    in   = 16'hFFFF;
    load = 1'b1;
    #1 chk("mid_rst_fwd", out, 16'h0000);
    @(posedge clk);
    #1 chk("mid_rst_edge", out, 16'h0000);
    load = 1'b0;
    #1 rst_n = 1'b1;
    model_clear();
    rd("post_rst_300", 14'd300);
    rd("post_rst_5", 14'd5);
    rd("post_rst_2112", 14'd2112);
    rd("post_rst_4096", 14'd4096);
    rd("post_rst_16383", 14'd16383);

    // Reset asserted in the same timestep as a write edge: reset wins
    @(negedge clk);
    address = 14'd100;
    in      = 16'h7777;
    load    = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    #1 load = 1'b0;
    #1 rst_n = 1'b1;
    rd("coinc_100", 14'd100);

    // Write-through behaviour at address 9
    @(negedge clk);
    address = 14'd9;
    in      = 16'h1234;
    load    = 1'b1;
    #1;
`ifdef RAM16K_WRITE_THROUGH_EN
    chk("wt_pre", out, 16'h1234);
`else
    chk("wt_pre", out, 16'h0000);
`endif
    @(posedge clk);
    #1 chk("wt_post", out, 16'h1234);
    load = 1'b0;
    #1 chk("wt_hold", out, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
